mac_vec: RTL

Parametrised vector multiply-accumulate engine. It is the successor to the single-lane MAC in the course datapath.
- Computes a dot product over LANES operand pairs per beat, accumulated across a programmed number of beats.
- Adds valid/ready handshakes, a one-stage product pipeline, a signed mode, and saturating or wrapping accumulation with overflow reporting.
- Sits between an operand stream source and a result consumer in the MATRIX datapath.

---
 rtl/mac_vec.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mac_vec.sv
// rtl/mac_vec.sv - parametrised vector multiply-accumulate engine
//
// Each accepted beat contributes the dot product of LANES operand pairs.
// The dot product is registered for one cycle and then added into a
// saturating or wrapping accumulator. After the programmed number of
// beats, the result is presented with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   start      one-cycle pulse, honoured only in IDLE
//   len        beat count, sampled with start (0 = empty operation)
//   sat_en     1 = saturate, 0 = wrap; sampled with start
//   in_valid   operand beat valid
//   in_ready   engine accepts a beat (ACCUM only)
//   a, b       packed operand lanes, lane i at [i*NBITS +: NBITS]
//   out_valid  result available
//   out_ready  consumer takes the result
//   result     accumulator register
//   overflow   sticky: the true sum left the ACC_BITS range this operation
//   busy       engine not in IDLE
module mac_vec #(
    parameter int NBITS    = 4,
    parameter int LANES    = 2,
    parameter int ACC_BITS = 2*NBITS+4,
    parameter int LEN_BITS = 8,
    parameter int SIGNED   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_BITS-1:0]       len,
    input  logic                      sat_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*NBITS-1:0]    a,
    input  logic [LANES*NBITS-1:0]    b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_BITS-1:0]       result,
    output logic                      overflow,
    output logic                      busy
);

    generate
        if (ACC_BITS < 2*NBITS + $clog2(LANES)) begin : g_acc_too_narrow
            $error("mac_vec: ACC_BITS must be at least 2*NBITS+clog2(LANES)");
        end
    endgenerate

    // Two guard bits so one accumulate step can never wrap before the range check.
    localparam int AW = ACC_BITS + 2;

    localparam logic signed [AW-1:0] HI = (SIGNED != 0) ?
        {3'b000, {(ACC_BITS-1){1'b1}}} : {2'b00, {ACC_BITS{1'b1}}};
    localparam logic signed [AW-1:0] LO = (SIGNED != 0) ?
        {3'b111, {(ACC_BITS-1){1'b0}}} : {AW{1'b0}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [LEN_BITS-1:0]        r_cnt;
    logic                       r_sat;
    logic signed [AW-1:0]       r_pipe;
    logic                       r_pipe_vld;
    logic [ACC_BITS-1:0]        r_acc;
    logic                       r_ovf;

    logic                       w_accept;
    logic signed [AW-1:0]       w_dot;
    logic signed [AW-1:0]       w_acc_ext;
    logic signed [AW-1:0]       w_sum;
    logic [ACC_BITS-1:0]        w_acc_nxt;
    logic                       w_ovf;

    function automatic logic signed [AW-1:0] f_ext_lane(input logic [NBITS-1:0] v);
        logic w_sx;
        w_sx = (SIGNED != 0) && v[NBITS-1];
        return {{(AW-NBITS){w_sx}}, v};
    endfunction

    // Dot product of the current beat; exact in AW bits because ACC_BITS
    // already covers 2*NBITS+clog2(LANES).
    always_comb begin : p_dot
        w_dot = '0;
        for (int i = 0; i < LANES; i++) begin
            w_dot = w_dot + f_ext_lane(a[i*NBITS +: NBITS]) * f_ext_lane(b[i*NBITS +: NBITS]);
        end
    end

    assign w_acc_ext = {{2{(SIGNED != 0) && r_acc[ACC_BITS-1]}}, r_acc};
    assign w_sum     = w_acc_ext + r_pipe;

    always_comb begin : p_range
        w_acc_nxt = w_sum[ACC_BITS-1:0];
        w_ovf     = 1'b0;
        if (w_sum > HI) begin
            w_ovf = 1'b1;
            if (r_sat) w_acc_nxt = HI[ACC_BITS-1:0];
        end else if (w_sum < LO) begin
            w_ovf = 1'b1;
            if (r_sat) w_acc_nxt = LO[ACC_BITS-1:0];
        end
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin : p_state
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = (len != '0) ? S_ACCUM : S_OUT;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && r_cnt == LEN_BITS'(1)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin : p_data
        if (reset) begin
            r_cnt      <= '0;
            r_sat      <= 1'b0;
            r_pipe     <= '0;
            r_pipe_vld <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_cnt      <= len;
                r_sat      <= sat_en;
                r_acc      <= '0;
                r_ovf      <= 1'b0;
                r_pipe_vld <= 1'b0;
            end
        end else begin
            if (r_pipe_vld) begin
                r_acc <= w_acc_nxt;
                if (w_ovf) r_ovf <= 1'b1;
            end
            r_pipe_vld <= w_accept;
            if (w_accept) begin
                r_pipe <= w_dot;
                r_cnt  <= r_cnt - LEN_BITS'(1);
            end
        end
    end

    assign result   = r_acc;
    assign overflow = r_ovf;

endmodule
